// File: rtl/byte_op_ctrl.sv
// Sequencer for the byte-group instructions (MOVL/MOVLZ/MOVLS/MOVH/SWPB) in front of byte_manip.
// Optional feature: define BYTE_OP_FWD_EN to accept start in WRITE and forward the result being written.
module byte_op_ctrl #(
   parameter int unsigned REG_AW    = 3,
   parameter int unsigned RF_RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [15:0]       instr,
   output logic              busy,
   output logic              done,
   output logic              illegal,
   output logic [REG_AW-1:0] rf_rd_addr,
   input  logic [15:0]       rf_rd_data,
   output logic [2:0]        bm_op,
   output logic [15:0]       bm_dst_in,
   output logic [7:0]        bm_byte,
   output logic              bm_E,
   input  logic [15:0]       bm_dst_out,
   output logic              rf_wr_en,
   output logic [REG_AW-1:0] rf_wr_addr,
   output logic [15:0]       rf_wr_data
);

   localparam int unsigned CNT_W = 2;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_READ    = 3'd1,
      S_STROBE  = 3'd2,
      S_CAPTURE = 3'd3,
      S_WRITE   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              illegal_q, illegal_d;
   logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
   logic [2:0]        op_q, op_d;
   logic [15:0]       dst_in_q, dst_in_d;
   logic [7:0]        byte_q, byte_d;
   logic              e_q, e_d;
   logic              wr_en_q, wr_en_d;
   logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
   logic [15:0]       wr_data_q, wr_data_d;

   // Instruction decode
   logic              is_grp, is_swpb, dec_legal;
   logic [2:0]        dec_op;
   logic [7:0]        dec_byte;
   logic [REG_AW-1:0] dec_dst;

   assign is_grp    = (instr[15:13] == 3'b011);
   assign is_swpb   = (instr[15:3] == 13'b0100_1101_1000_0);
   assign dec_legal = is_grp | is_swpb;
   assign dec_op    = is_swpb ? 3'd4 : {1'b0, instr[12:11]};
   assign dec_byte  = is_swpb ? 8'h00 : instr[10:3];
   assign dec_dst   = REG_AW'(instr[2:0]);

   // End of the read phase and the value captured into bm_dst_in
   logic        rd_last, rd_done;
   logic [15:0] rd_val;
   assign rd_last = (cnt_q == CNT_W'(RF_RD_LAT - 1));

`ifdef BYTE_OP_FWD_EN
   logic fwd_q, fwd_d;
   assign rd_done = rd_last | fwd_q;
   assign rd_val  = fwd_q ? wr_data_q : rf_rd_data;
`else
   assign rd_done = rd_last;
   assign rd_val  = rf_rd_data;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         rd_addr_q <= '0;
         op_q      <= '0;
         dst_in_q  <= '0;
         byte_q    <= '0;
         e_q       <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
`ifdef BYTE_OP_FWD_EN
         fwd_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
         rd_addr_q <= rd_addr_d;
         op_q      <= op_d;
         dst_in_q  <= dst_in_d;
         byte_q    <= byte_d;
         e_q       <= e_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
`ifdef BYTE_OP_FWD_EN
         fwd_q     <= fwd_d;
`endif
      end
   end

   always_comb begin
      logic acc_ok;
      state_d   = state_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      rd_addr_d = rd_addr_q;
      op_d      = op_q;
      dst_in_d  = dst_in_q;
      byte_d    = byte_q;
      e_d       = 1'b0;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      acc_ok    = 1'b0;
`ifdef BYTE_OP_FWD_EN
      fwd_d     = fwd_q;
`endif

      case (state_q)
         S_IDLE: acc_ok = 1'b1;
         S_READ: begin
            if (rd_done) begin
               dst_in_d = rd_val;
               cnt_d    = '0;
               e_d      = 1'b1;
               state_d  = S_STROBE;
`ifdef BYTE_OP_FWD_EN
               fwd_d    = 1'b0;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STROBE: state_d = S_CAPTURE;
         S_CAPTURE: begin
            wr_data_d = bm_dst_out;
            wr_addr_d = rd_addr_q;
            wr_en_d   = 1'b1;
            done_d    = 1'b1;
            state_d   = S_WRITE;
         end
         S_WRITE: begin
            state_d = S_IDLE;
`ifdef BYTE_OP_FWD_EN
            acc_ok  = 1'b1;
`endif
         end
         default: state_d = S_IDLE;
      endcase

      // Accept a new instruction; illegal ones only raise the pulse
      if (acc_ok && start) begin
         if (dec_legal) begin
            op_d      = dec_op;
            byte_d    = dec_byte;
            rd_addr_d = dec_dst;
            cnt_d     = '0;
            state_d   = S_READ;
`ifdef BYTE_OP_FWD_EN
            fwd_d     = (state_q == S_WRITE) && (dec_dst == wr_addr_q);
`endif
         end else begin
            illegal_d = 1'b1;
         end
      end

      busy_d = (state_d != S_IDLE);
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign illegal    = illegal_q;
   assign rf_rd_addr = rd_addr_q;
   assign bm_op      = op_q;
   assign bm_dst_in  = dst_in_q;
   assign bm_byte    = byte_q;
   assign bm_E       = e_q;
   assign rf_wr_en   = wr_en_q;
   assign rf_wr_addr = wr_addr_q;
   assign rf_wr_data = wr_data_q;

endmodule

// File: tb/tb_byte_op_ctrl.sv
// Randomized bench for byte_op_ctrl with register-file and byte_manip stand-ins and a reference model.
module tb_byte_op_ctrl;

   localparam int unsigned REG_AW = 3;
   localparam int unsigned LAT    = 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [15:0]       instr;
   logic              busy, done, illegal;
   logic [REG_AW-1:0] rf_rd_addr;
   logic [15:0]       rf_rd_data;
   logic [2:0]        bm_op;
   logic [15:0]       bm_dst_in;
   logic [7:0]        bm_byte;
   logic              bm_E;
   logic [15:0]       bm_dst_out = 16'h0;
   logic              rf_wr_en;
   logic [REG_AW-1:0] rf_wr_addr;
   logic [15:0]       rf_wr_data;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   byte_op_ctrl #(.REG_AW(REG_AW), .RF_RD_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .instr(instr),
      .busy(busy), .done(done), .illegal(illegal),
      .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
      .bm_op(bm_op), .bm_dst_in(bm_dst_in), .bm_byte(bm_byte), .bm_E(bm_E),
      .bm_dst_out(bm_dst_out),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
   );

   always #5 clk = ~clk;

   // Register file: single-cycle read path, write on rf_wr_en, bench preload port
   logic [15:0] mem [8];
   logic        pl_en = 1'b0;
   logic [2:0]  pl_addr = 3'd0;
   logic [15:0] pl_data = 16'h0;
   int unsigned wr_cnt = 0;

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (rf_wr_en) begin
         mem[rf_wr_addr] <= rf_wr_data;
         wr_cnt          <= wr_cnt + 1;
      end
   end
   assign rf_rd_data = mem[rf_rd_addr];

   // byte_manip stand-in: result registered on the E strobe
   always @(posedge clk) begin
      if (bm_E) begin
         case (bm_op)
            3'd0:    bm_dst_out <= {bm_dst_in[15:8], bm_byte};
            3'd1:    bm_dst_out <= {8'h00, bm_byte};
            3'd2:    bm_dst_out <= {{8{bm_byte[7]}}, bm_byte};
            3'd3:    bm_dst_out <= {bm_byte, bm_dst_in[7:0]};
            3'd4:    bm_dst_out <= {bm_dst_in[7:0], bm_dst_in[15:8]};
            default: bm_dst_out <= 16'hDEAD;
         endcase
      end
   end

   logic [15:0] ref_mem [8];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit ref_legal(input logic [15:0] ins);
      int unsigned i;
      i = 32'(ins);
      return ((i >> 13) == 3) || ((i >> 3) == 32'h9B0);
   endfunction

   function automatic bit ref_swpb(input logic [15:0] ins);
      int unsigned i;
      i = 32'(ins);
      return (i >> 3) == 32'h9B0;
   endfunction

   function automatic logic [15:0] ref_exec(input logic [15:0] ins, input logic [15:0] old);
      int unsigned i, o, b, v;
      i = 32'(ins);
      o = 32'(old);
      b = (i >> 3) & 255;
      if (ref_swpb(ins)) v = ((o & 255) << 8) | (o >> 8);
      else begin
         case ((i >> 11) & 3)
            0:       v = (o & 32'hFF00) | b;
            1:       v = b;
            2:       v = (b >= 128) ? (b | 32'hFF00) : b;
            default: v = (b << 8) | (o & 255);
         endcase
      end
      return 16'(v);
   endfunction

   task automatic preload(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic run_op(input logic [15:0] ins);
      logic [2:0]  d;
      logic [15:0] e;
      int          k_e, n_e, k_w;
      bit          busy_ok;
      int unsigned wc0, eop, ebyte;
      d     = ins[2:0];
      e     = ref_exec(ins, ref_mem[d]);
      eop   = ref_swpb(ins) ? 4 : ((32'(ins) >> 11) & 3);
      ebyte = ref_swpb(ins) ? 0 : ((32'(ins) >> 3) & 255);
      wc0   = wr_cnt;
      @(negedge clk);
      start = 1'b1; instr = ins;
      @(negedge clk);
      start = 1'b0; instr = 16'($urandom);
      if (!ref_legal(ins)) begin
         chk("illegal_pulse", 32'(illegal), 1);
         chk("illegal_busy", 32'(busy), 0);
         @(negedge clk);
         chk("illegal_clear", 32'(illegal), 0);
         repeat (4) @(negedge clk);
         chk("illegal_nowrite", wr_cnt - wc0, 0);
         return;
      end
      k_e = -1; n_e = 0; k_w = -1; busy_ok = 1'b1;
      for (int k = 1; k <= 20 && k_w < 0; k++) begin
         if (k > 1) @(negedge clk);
         if (!busy) busy_ok = 1'b0;
         if (bm_E) begin
            n_e++;
            if (k_e < 0) begin
               k_e = k;
               chk("strobe_op", 32'(bm_op), eop);
               chk("strobe_byte", 32'(bm_byte), ebyte);
               chk("strobe_dst_in", 32'(bm_dst_in), 32'(ref_mem[d]));
            end
         end
         if (rf_wr_en) begin
            k_w = k;
            chk("done_with_wr", 32'(done), 1);
            chk("wr_addr", 32'(rf_wr_addr), 32'(d));
            chk("wr_data", 32'(rf_wr_data), 32'(e));
         end
      end
      chk("strobe_cycle", 32'(k_e), LAT + 1);
      chk("strobe_count", 32'(n_e), 1);
      chk("write_cycle", 32'(k_w), LAT + 3);
      chk("busy_during", 32'(busy_ok), 1);
      @(negedge clk);
      chk("idle_after", 32'(busy), 0);
      chk("done_clear", 32'(done), 0);
      ref_mem[d] = e;
      chk("rf_content", 32'(mem[d]), 32'(ref_mem[d]));
   endtask

   task automatic reset_mid_strobe();
      int unsigned wc0;
      preload(3'd3, 16'h1234);
      wc0 = wr_cnt;
      @(negedge clk);
      start = 1'b1; instr = 16'h655B;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("rst_pre_strobe", 32'(bm_E), 1);
      rst = 1'b1;
      #1;
      chk("rst_ctrl", 32'({busy, done, illegal, bm_E, rf_wr_en, rf_rd_addr, rf_wr_addr, bm_op}), 0);
      chk("rst_dst_in", 32'(bm_dst_in), 0);
      chk("rst_byte", 32'(bm_byte), 0);
      chk("rst_wr_data", 32'(rf_wr_data), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_nowrite", wr_cnt - wc0, 0);
      chk("rst_r3_kept", 32'(mem[3]), 32'h1234);
      chk("rst_idle", 32'(busy), 0);
      run_op(16'h655B);
   endtask

   task automatic back_to_back();
      int t1, t2;
      preload(3'd3, 16'h1234);
      t1 = -1; t2 = -1;
      @(negedge clk);
      start = 1'b1; instr = 16'h655B;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (rf_wr_en && done) begin
            if (t1 < 0) begin
               t1 = k;
               chk("b2b_first", 32'(rf_wr_data), 32'h12AB);
               start = 1'b1; instr = 16'h7D5B;
            end else if (t2 < 0) begin
               t2 = k;
               chk("b2b_second", 32'(rf_wr_data), 32'hABAB);
            end
         end
      end
`ifdef BYTE_OP_FWD_EN
      chk("b2b_gap", 32'(t2 - t1), 4);
      ref_mem[3] = 16'hABAB;
`else
      chk("b2b_ignored", 32'(t2), 32'hFFFF_FFFF);
      ref_mem[3] = 16'h12AB;
`endif
      chk("b2b_r3", 32'(mem[3]), 32'(ref_mem[3]));
      chk("b2b_idle", 32'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ins;
      rst = 1'b1; start = 1'b0; instr = 16'h0;
      repeat (2) @(negedge clk);
      chk("reset_ctrl", 32'({busy, done, illegal, bm_E, rf_wr_en}), 0);
      chk("reset_wr_data", 32'(rf_wr_data), 0);
      rst = 1'b0;
      for (int a = 0; a < 8; a++) preload(3'(a), 16'($urandom));

      preload(3'd3, 16'h1234); run_op(16'h655B);
      preload(3'd3, 16'h1234); run_op(16'h6D5B);
      preload(3'd3, 16'h1234); run_op(16'h755B);
      preload(3'd3, 16'h1234); run_op(16'h7D5B);
      preload(3'd3, 16'h1234); run_op(16'h4D83);
      run_op(16'h0000);

      reset_mid_strobe();
      back_to_back();

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0, 1:    ins = {3'b011, 13'($urandom)};
            2:       ins = {13'h09B0, 3'($urandom)};
            default: ins = 16'($urandom);
         endcase
         run_op(ins);
      end
      for (int a = 0; a < 8; a++) chk("final_rf", 32'(mem[a]), 32'(ref_mem[a]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
